vector_config_ctrl: RTL and testbench

//  Sequences vsetvli/vsetivli/vsetvl in the decode/execute path and owns the architectural vl and vtype registers.

---
 rtl/vector_config_ctrl_pkg.sv | 25 ++
 rtl/vector_config_ctrl_chk.sv | 21 ++
 rtl/vector_config_ctrl_vtype_decoder.sv | 53 +++++
 rtl/vector_config_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vector_config_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_config_ctrl_pkg.sv
// Shared encodings for the vector configuration controller: request kinds,
// vtype field codes, the illegal-vtype value and the sequencing states.
package vector_config_ctrl_pkg;

  localparam logic [1:0]  KIND_VSETVLI  = 2'b00;
  localparam logic [1:0]  KIND_VSETIVLI = 2'b01;
  localparam logic [1:0]  KIND_VSETVL   = 2'b10;

  localparam logic [2:0]  VLMUL_RSVD    = 3'b100;

  localparam logic [31:0] VTYPE_VILL     = 32'h8000_0000;
  localparam logic [31:0] VTYPE_RSV_MASK = 32'hFFFF_FF00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DRAIN   = 2'b01,
    ST_COMPUTE = 2'b10,
    ST_RESP    = 2'b11
  } cfg_state_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vector_config_ctrl_chk.sv
// Simulation-only protocol checks on the vector issue/retire interface.
module vector_config_ctrl_chk (
  input logic clock,
  input logic reset_n,
  input logic vec_issue,
  input logic vec_retire,
  input logic cfg_busy,
  input logic inflight_full,
  input logic count_zero
);

  a_issue_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(vec_issue && !vec_retire && inflight_full));

  a_retire_when_empty: assert property (@(posedge clock) disable iff (!reset_n)
    !(vec_retire && !vec_issue && count_zero));

  a_issue_when_busy: assert property (@(posedge clock) disable iff (!reset_n)
    !(vec_issue && cfg_busy));

endmodule

// File: rtl/vector_config_ctrl_vtype_decoder.sv
// Combinational vtype legality check and VLMAX computation for a given
// VLEN/ELEN; an illegal vtype yields vill=1, vtype=0 and vlmax=0.
module vtype_decoder
  import vector_config_ctrl_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [31:0] vtype_raw_i,
  input  logic [31:0] rsv_mask_i,
  output logic        vill_o,
  output logic [7:0]  vtype_o,
  output logic [31:0] vlmax_o
);

  localparam logic [31:0] VLEN_W = 32'(VLEN);
  localparam logic [31:0] ELEN_W = 32'(ELEN);

  logic [2:0]  vsew_s;
  logic [2:0]  vlmul_s;
  logic        frac_s;
  logic [4:0]  frac_sh_s;
  logic [31:0] sew_s;
  logic [31:0] per_reg_s;
  logic [31:0] elen_frac_s;

  // Fractional LMUL 2^-k is encoded as 8-k, so a right shift by (8-vlmul) scales by it.
  always_comb begin
    vsew_s      = vtype_raw_i[5:3];
    vlmul_s     = vtype_raw_i[2:0];
    frac_s      = vlmul_s[2];
    frac_sh_s   = 5'd8 - {2'b00, vlmul_s};
    sew_s       = 32'd8 << vsew_s;
    per_reg_s   = VLEN_W >> (5'd3 + {2'b00, vsew_s});
    elen_frac_s = ELEN_W >> frac_sh_s;
    vill_o      = vsew_s[2]
                | (sew_s > ELEN_W)
                | (vlmul_s == VLMUL_RSVD)
                | (frac_s & (sew_s > elen_frac_s))
                | (|(vtype_raw_i & rsv_mask_i));
    if (vill_o) begin
      vtype_o = 8'd0;
      vlmax_o = 32'd0;
    end else if (frac_s) begin
      vtype_o = vtype_raw_i[7:0];
      vlmax_o = per_reg_s >> frac_sh_s;
    end else begin
      vtype_o = vtype_raw_i[7:0];
      vlmax_o = per_reg_s << vlmul_s;
    end
  end

endmodule

// File: rtl/vector_config_ctrl.sv
// Sequences vsetvli/vsetivli/vsetvl: drains in-flight vector ops, computes the
// new vl from AVL and vtype, updates the architectural vl/vtype and returns vl.
module vector_config_ctrl
  import vector_config_ctrl_pkg::*;
#(
  parameter int VLEN         = 128,
  parameter int ELEN         = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic        rs1_is_x0,
  input  logic        rd_is_x0,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  uimm,
  input  logic [10:0] zimm,
  input  logic [31:0] rs2_val,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_vl,
  output logic [31:0] vl_o,
  output logic [31:0] vtype_o,
  output logic        vill_o,
  output logic        cfg_busy,
  input  logic        vec_issue,
  input  logic        vec_retire,
  output logic        inflight_full
);

  localparam int            CW       = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  cfg_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic        accept_s;
  logic [1:0]  kind_q;
  logic        rs1_x0_q, rd_x0_q;
  logic [31:0] rs1_val_q, rs2_val_q;
  logic [4:0]  uimm_q;
  logic [10:0] zimm_q;
  logic [31:0] vl_q, vl_d, vtype_q, vtype_d, rsp_vl_q, rsp_vl_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] raw_vtype_s, avl_s, new_vl_s, dec_vlmax_s;
  logic [7:0]  dec_vtype_s;
  logic        dec_vill_s, kind_bad_s, vill_s;

  // In-flight counter; saturating at both ends, simultaneous issue+retire cancels.
  always_comb begin
    count_d = count_q;
    if (vec_issue && !vec_retire) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
      else                    count_d = count_q;
    end else if (vec_retire && !vec_issue) begin
      if (count_q != CNT_ZERO) count_d = count_q - CNT_ONE;
      else                     count_d = count_q;
    end else begin
      count_d = count_q;
    end
  end

  // Sequencing: skip DRAIN when nothing will be in flight after the accept edge.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_d  = (count_d == CNT_ZERO) ? ST_COMPUTE : ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN:   state_d = (count_q == CNT_ZERO) ? ST_COMPUTE : ST_DRAIN;
      ST_COMPUTE: state_d = ST_RESP;
      ST_RESP:    state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default:    state_d = ST_IDLE;
    endcase
  end

  // AVL selection and raw vtype assembly from the latched operands.
  always_comb begin
    raw_vtype_s = 32'd0;
    kind_bad_s  = 1'b0;
    case (kind_q)
      KIND_VSETVLI:  raw_vtype_s = {21'd0, zimm_q};
      KIND_VSETIVLI: raw_vtype_s = {22'd0, zimm_q[9:0]};
      KIND_VSETVL:   raw_vtype_s = rs2_val_q;
      default:       kind_bad_s  = 1'b1;
    endcase
    if (kind_q == KIND_VSETIVLI) avl_s = {27'd0, uimm_q};
    else if (!rs1_x0_q)          avl_s = rs1_val_q;
    else if (!rd_x0_q)           avl_s = 32'hFFFF_FFFF;
    else                         avl_s = vl_q;
  end

  vtype_decoder #(
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) u_vtype_decoder (
    .vtype_raw_i(raw_vtype_s),
    .rsv_mask_i (VTYPE_RSV_MASK),
    .vill_o     (dec_vill_s),
    .vtype_o    (dec_vtype_s),
    .vlmax_o    (dec_vlmax_s)
  );

  assign vill_s   = dec_vill_s | kind_bad_s;
  assign new_vl_s = vill_s ? 32'd0 : min_u32(avl_s, dec_vlmax_s);

  // Architectural registers and the response all update on the COMPUTE exit edge.
  always_comb begin
    vl_d        = vl_q;
    vtype_d     = vtype_q;
    rsp_vl_d    = rsp_vl_q;
    rsp_valid_d = rsp_valid_q;
    if (state_q == ST_COMPUTE) begin
      vl_d        = new_vl_s;
      vtype_d     = vill_s ? VTYPE_VILL : {24'd0, dec_vtype_s};
      rsp_vl_d    = new_vl_s;
      rsp_valid_d = 1'b1;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State, counter and architectural registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_ZERO;
      vl_q        <= 32'd0;
      vtype_q     <= VTYPE_VILL;
      rsp_vl_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      vl_q        <= vl_d;
      vtype_q     <= vtype_d;
      rsp_vl_q    <= rsp_vl_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Operand capture on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind_q    <= 2'b00;
      rs1_x0_q  <= 1'b0;
      rd_x0_q   <= 1'b0;
      rs1_val_q <= 32'd0;
      uimm_q    <= 5'd0;
      zimm_q    <= 11'd0;
      rs2_val_q <= 32'd0;
    end else if (accept_s) begin
      kind_q    <= req_kind;
      rs1_x0_q  <= rs1_is_x0;
      rd_x0_q   <= rd_is_x0;
      rs1_val_q <= rs1_val;
      uimm_q    <= uimm;
      zimm_q    <= zimm;
      rs2_val_q <= rs2_val;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign cfg_busy      = (state_q != ST_IDLE);
  assign inflight_full = (count_q == CNT_MAX);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_vl        = rsp_vl_q;
  assign vl_o          = vl_q;
  assign vtype_o       = vtype_q;
  assign vill_o        = vtype_q[31];

  vector_config_ctrl_chk u_chk (
    .clock        (clock),
    .reset_n      (reset_n),
    .vec_issue    (vec_issue),
    .vec_retire   (vec_retire),
    .cfg_busy     (cfg_busy),
    .inflight_full(inflight_full),
    .count_zero   (count_q == CNT_ZERO)
  );

endmodule

// File: tb/tb_vector_config_ctrl.sv
// Directed bench for vector_config_ctrl: an abstract reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_vector_config_ctrl;

  localparam int VLEN = 128;
  localparam int ELEN = 32;
  localparam int MAXI = 4;

  logic        clock, reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic        rs1_is_x0, rd_is_x0;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  uimm;
  logic [10:0] zimm;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_vl, vl_o, vtype_o;
  logic        vill_o, cfg_busy, vec_issue, vec_retire, inflight_full;

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  int          m_count     = 0;
  bit          m_busy      = 1'b0;
  int          m_since     = -1;
  bit          m_rsp_valid = 1'b0;
  logic [31:0] m_vl        = 32'd0;
  logic [31:0] m_vtype     = 32'h8000_0000;
  logic [31:0] m_rsp_vl    = 32'd0;
  logic [1:0]  m_kind;
  bit          m_r1x0, m_rdx0;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_ui;
  logic [10:0] m_zi;

  vector_config_ctrl #(.VLEN(VLEN), .ELEN(ELEN), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .rs1_is_x0(rs1_is_x0), .rd_is_x0(rd_is_x0), .rs1_val(rs1_val),
    .uimm(uimm), .zimm(zimm), .rs2_val(rs2_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vl(rsp_vl),
    .vl_o(vl_o), .vtype_o(vtype_o), .vill_o(vill_o), .cfg_busy(cfg_busy),
    .vec_issue(vec_issue), .vec_retire(vec_retire), .inflight_full(inflight_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Configuration result straight from the architectural rules, using LMUL as a fraction num/den.
  function automatic void ref_cfg(input logic [1:0] kind, input bit r1x0, input bit rdx0,
                                  input logic [31:0] rs1, input logic [4:0] ui, input logic [10:0] zi,
                                  input logic [31:0] rs2, input logic [31:0] cur_vl,
                                  output logic [31:0] vl, output logic [31:0] vt);
    logic [31:0] raw;
    bit     ill;
    int     vsew, vlmul, sew, num, den;
    longint vlmax, avl;
    ill = 1'b0;
    raw = 32'd0;
    case (kind)
      2'b00:   raw = {21'd0, zi};
      2'b01:   raw = {22'd0, zi[9:0]};
      2'b10:   raw = rs2;
      default: ill = 1'b1;
    endcase
    if (raw[31:8] != 24'd0) ill = 1'b1;
    vsew  = int'(raw[5:3]);
    vlmul = int'(raw[2:0]);
    sew   = 8 * (1 << vsew);
    if (vsew >= 4 || sew > ELEN) ill = 1'b1;
    num = 1;
    den = 1;
    case (vlmul)
      0: num = 1;
      1: num = 2;
      2: num = 4;
      3: num = 8;
      5: den = 8;
      6: den = 4;
      7: den = 2;
      default: ill = 1'b1;
    endcase
    if (den > 1 && sew * den > ELEN) ill = 1'b1;
    vlmax = longint'((VLEN * num) / (sew * den));
    if (kind == 2'b01)  avl = longint'({27'd0, ui});
    else if (!r1x0)     avl = longint'({32'd0, rs1});
    else if (!rdx0)     avl = longint'(32'hFFFF_FFFF);
    else                avl = longint'({32'd0, cur_vl});
    if (ill) begin
      vl = 32'd0;
      vt = 32'h8000_0000;
    end else begin
      vl = (avl < vlmax) ? avl[31:0] : vlmax[31:0];
      vt = {24'd0, raw[7:0]};
    end
  endfunction

  // Reference model: rsp appears two cycles after the first cycle with nothing in flight.
  always @(posedge clock or negedge reset_n) begin
    logic [31:0] nvl, nvt;
    if (!reset_n) begin
      m_count = 0; m_busy = 1'b0; m_since = -1; m_rsp_valid = 1'b0;
      m_vl = 32'd0; m_vtype = 32'h8000_0000; m_rsp_vl = 32'd0;
    end else begin
      if (vec_issue && !vec_retire && m_count < MAXI) m_count++;
      else if (vec_retire && !vec_issue && m_count > 0) m_count--;
      if (m_rsp_valid) begin
        if (rsp_ready) begin
          m_rsp_valid = 1'b0;
          m_busy      = 1'b0;
        end
      end else if (m_busy) begin
        if (m_since >= 0) m_since++;
        else if (m_count == 0) m_since = 0;
        if (m_since == 2) begin
          ref_cfg(m_kind, m_r1x0, m_rdx0, m_rs1, m_ui, m_zi, m_rs2, m_vl, nvl, nvt);
          m_vl = nvl; m_vtype = nvt; m_rsp_vl = nvl; m_rsp_valid = 1'b1;
        end
      end else if (req_valid) begin
        m_busy = 1'b1;
        m_kind = req_kind; m_r1x0 = rs1_is_x0; m_rdx0 = rd_is_x0;
        m_rs1 = rs1_val; m_rs2 = rs2_val; m_ui = uimm; m_zi = zimm;
        m_since = (m_count == 0) ? 1 : -1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (run_chk) begin
      chk("vl_o",          vl_o,                     m_vl);
      chk("vtype_o",       vtype_o,                  m_vtype);
      chk("vill_o",        {31'd0, vill_o},          {31'd0, m_vtype[31]});
      chk("req_ready",     {31'd0, req_ready},       {31'd0, !m_busy});
      chk("cfg_busy",      {31'd0, cfg_busy},        {31'd0, m_busy});
      chk("inflight_full", {31'd0, inflight_full},   {31'd0, (m_count == MAXI)});
      chk("rsp_valid",     {31'd0, rsp_valid},       {31'd0, m_rsp_valid});
      chk("rsp_vl",        rsp_vl,                   m_rsp_vl);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic send_req(input logic [1:0] k, input bit r1x0, input bit rdx0, input logic [31:0] rs1,
                          input logic [4:0] ui, input logic [10:0] zi, input logic [31:0] rs2);
    step();
    req_kind = k; rs1_is_x0 = r1x0; rd_is_x0 = rdx0;
    rs1_val = rs1; uimm = ui; zimm = zi; rs2_val = rs2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // exp_n counts clock edges from the current cycle until rsp_valid is seen.
  task automatic wait_rsp(input string nm, input logic [31:0] exp_vl, input int exp_n, input bit ack);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_n));
    chk({nm, "_rsp_vl"}, rsp_vl, exp_vl);
    if (ack) begin
      #1 rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clock = 1'b0; reset_n = 1'b1;
    req_valid = 1'b0; req_kind = 2'b00; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
    rs1_val = 32'd0; rs2_val = 32'd0; uimm = 5'd0; zimm = 11'd0;
    rsp_ready = 1'b0; vec_issue = 1'b0; vec_retire = 1'b0;
    #2 reset_n = 1'b0;
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_vtype",     vtype_o,            32'h8000_0000);
    chk("rst_vill",      {31'd0, vill_o},    32'd1);
    chk("rst_vl",        vl_o,               32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    run_chk = 1'b1;
    step();
    reset_n = 1'b1;

    send_req(2'b00, 1'b0, 1'b0, 32'd10, 5'd0, 11'h010, 32'd0);
    wait_rsp("t1", 32'd4, 1, 1'b1);
    chk("t1_vtype", vtype_o, 32'h0000_0010);

    send_req(2'b01, 1'b0, 1'b0, 32'd0, 5'd3, 11'h001, 32'd0);
    wait_rsp("t2", 32'd3, 1, 1'b1);
    chk("t2_vl", vl_o, 32'd3);

    send_req(2'b00, 1'b1, 1'b0, 32'd0, 5'd0, 11'h00B, 32'd0);
    wait_rsp("t3a", 32'd64, 1, 1'b1);
    send_req(2'b00, 1'b1, 1'b1, 32'd0, 5'd0, 11'h00B, 32'd0);
    wait_rsp("t3b", 32'd64, 1, 1'b1);
    chk("t3b_vl", vl_o, 32'd64);

    send_req(2'b10, 1'b0, 1'b0, 32'd50, 5'd0, 11'h000, 32'h0000_0018);
    wait_rsp("t4", 32'd0, 1, 1'b1);
    chk("t4_vtype", vtype_o, 32'h8000_0000);
    chk("t4_vill",  {31'd0, vill_o}, 32'd1);

    send_req(2'b00, 1'b1, 1'b1, 32'd0, 5'd0, 11'h010, 32'd0);
    wait_rsp("avl_cur_zero", 32'd0, 1, 1'b1);
    send_req(2'b10, 1'b0, 1'b0, 32'd3, 5'd0, 11'h000, 32'h0000_00D0);
    wait_rsp("vsetvl_tama", 32'd3, 1, 1'b1);
    chk("vsetvl_tama_vtype", vtype_o, 32'h0000_00D0);
    send_req(2'b00, 1'b0, 1'b0, 32'd100, 5'd0, 11'h006, 32'd0);
    wait_rsp("frac_quarter", 32'd4, 1, 1'b1);
    send_req(2'b00, 1'b0, 1'b0, 32'd100, 5'd0, 11'h005, 32'd0);
    wait_rsp("frac_eighth_ill", 32'd0, 1, 1'b1);
    send_req(2'b00, 1'b0, 1'b0, 32'd100, 5'd0, 11'h004, 32'd0);
    wait_rsp("lmul_rsvd_ill", 32'd0, 1, 1'b1);
    send_req(2'b00, 1'b0, 1'b0, 32'd100, 5'd0, 11'h110, 32'd0);
    wait_rsp("zimm_rsvd_ill", 32'd0, 1, 1'b1);
    send_req(2'b00, 1'b0, 1'b0, 32'd100, 5'd0, 11'h020, 32'd0);
    wait_rsp("vsew_big_ill", 32'd0, 1, 1'b1);
    send_req(2'b11, 1'b0, 1'b0, 32'd100, 5'd0, 11'h010, 32'd0);
    wait_rsp("kind_rsvd_ill", 32'd0, 1, 1'b1);
    send_req(2'b10, 1'b0, 1'b0, 32'd100, 5'd0, 11'h000, 32'h8000_0010);
    wait_rsp("rs2_vill_bit", 32'd0, 1, 1'b1);
    send_req(2'b01, 1'b0, 1'b0, 32'd0, 5'd31, 11'h410, 32'd0);
    wait_rsp("ivli_bit10", 32'd4, 1, 1'b1);
    chk("ivli_bit10_vtype", vtype_o, 32'h0000_0010);
    send_req(2'b00, 1'b0, 1'b0, 32'hFFFF_FFFE, 5'd0, 11'h003, 32'd0);
    wait_rsp("avl_large", 32'd128, 1, 1'b1);

    vec_issue = 1'b1;
    step();
    step();
    vec_retire = 1'b1;
    step();
    vec_retire = 1'b0;
    chk("t5_not_full_at2", {31'd0, inflight_full}, 32'd0);
    step();
    step();
    vec_issue = 1'b0;
    chk("t5_full_at4", {31'd0, inflight_full}, 32'd1);
    vec_retire = 1'b1;
    step();
    step();
    vec_retire = 1'b0;
    send_req(2'b00, 1'b0, 1'b0, 32'd10, 5'd0, 11'h010, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_drain_busy", {31'd0, cfg_busy}, 32'd1);
      chk("t5_drain_norsp", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    vec_retire = 1'b1;
    step();
    step();
    vec_retire = 1'b0;
    wait_rsp("t5", 32'd4, 2, 1'b1);

    send_req(2'b00, 1'b0, 1'b0, 32'd2, 5'd0, 11'h010, 32'd0);
    wait_rsp("t6", 32'd2, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold_rsp", {31'd0, rsp_valid}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_rst_vl",        vl_o,               32'd0);
    chk("t6_rst_vtype",     vtype_o,            32'h8000_0000);
    chk("t6_rst_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    send_req(2'b00, 1'b0, 1'b0, 32'd10, 5'd0, 11'h010, 32'd0);
    wait_rsp("after_rst", 32'd4, 1, 1'b1);
    step();

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
